bus_transfer_sequencer: RTL and testbench
=========================================

// Module: bus_transfer_sequencer
// PURPOSE
//  Owns the shared 16-bit register bus of the CPU. Arbitrates register-transfer requests from
//  NREQ requesters (port 0 = control unit, port 1 = I/O/DMA) round-robin, then sequences each
//  transfer. It drives the 5-bit register-mux select, settles the bus, and pulses exactly one
//  destination register load enable. Sits between the control unit and the register-file mux.
// PARAMETERS
//  NREQ    2   number of requesters (>=2)
//  NREGS   16  registers on the bus (r0..r15)
//  SEL_W   5   mux select width; code 0 = bus idle, k = r(k-1), NREGS+1 = external data
//  SETTLE  1   cycles the source drives the bus before the load strobe (>=1)
// PORTS
//  clk         in   1            single system clock, rising edge
//  rst_n       in   1            asynchronous, active-low reset
//  req_valid   in   NREQ         request pending per requester
//  req_src     in   NREQ*SEL_W   source mux code per requester (slice i = [i*SEL_W +: SEL_W])
//  req_dst     in   NREQ*4       destination register index 0..15 per requester
//  req_ready   out  NREQ         grant; a request is accepted when valid & ready on a rising edge
//  done        out  NREQ         1-cycle pulse to the accepted requester on completion
//  mux_sel     out  SEL_W        register-mux select code
//  ext_drive   out  1            enables the external data driver onto the bus
//  reg_load    out  NREGS        one-hot destination load enable
//  busy        out  1            high whenever state != IDLE
//  err         out  1            sticky illegal-source flag
//  err_clr     in   1            synchronous clear of err
// BEHAVIOUR
//  - Reset (async, immediate): state=IDLE, mux_sel=0, ext_drive=0, reg_load=0, done=0,
//    req_ready=0, busy=0, err=0, rr pointer=0. A transfer cut by reset is dropped and never loads.
//  - States: IDLE -> DRIVE (SETTLE cycles) -> LOAD (1 cycle) -> IDLE.
//  - IDLE: mux_sel=0. req_ready is combinational from req_valid and the rr pointer, is one-hot,
//    and is asserted only in IDLE. On acceptance, latch src, dst and grant id.
//  - Round robin: search starts at the pointer. After a grant to g, pointer = (g+1) mod NREQ.
//    Simultaneous requests straight out of reset are granted to requester 0 first.
//  - DRIVE: mux_sel = latched src. ext_drive=1 iff src==NREGS+1. A settle counter counts SETTLE
//    cycles, then the block moves to LOAD.
//  - LOAD: mux_sel/ext_drive held, reg_load[dst]=1 and done[g]=1 for exactly one cycle.
//  - Timing: acceptance edge ends cycle 0; DRIVE = cycles 1..SETTLE; LOAD = cycle SETTLE+1;
//    IDLE = cycle SETTLE+2. Throughput is one transfer per SETTLE+2 cycles.
//  - There is always one IDLE cycle with mux_sel=0 between transfers, so no two sources drive
//    back-to-back.
//  - src==0: accepted; skip DRIVE; LOAD cycle has reg_load=0 and done pulses.
//  - src>NREGS+1: accepted; err<=1; handled like src==0 (no drive, no load, done pulses).
//  - err_clr and a new error in the same cycle: set wins.
//  - src==dst+1 (self-copy) is legal and executes normally.
//  - Dropping req_valid before the grant has no effect. req_src/req_dst are sampled only on
//    acceptance and may change afterwards.
//  - reg_load and done are registered outputs, so they are glitch-free.
// STRUCTURE
//  - Package bus_pkg: SEL_W, SEL_NONE=0, SEL_EXT=NREGS+1, state enum
//    {IDLE, DRIVE, LOAD}, function reg_sel(idx)=idx+1.
//  - Sub-module rr_arbiter #(NREQ): inputs req, ptr; output one-hot gnt (combinational).
//  - Top level holds the FSM, settle counter, latches and err flag.
// TESTING
//  - Single: req0 src=3 (r2), dst=5 -> mux_sel=3 on cycles 1..SETTLE;
//    reg_load=16'h0020 and done[0] on cycle SETTLE+1; busy=0 on cycle SETTLE+2.
//  - Contention: both valid continuously after reset -> grants alternate 0,1,0,1;
//    each starts SETTLE+2 cycles apart; mux_sel=0 for one cycle between transfers.
//  - External: src=17, dst=15 -> ext_drive=1 through DRIVE/LOAD; reg_load=16'h8000.
//  - Illegal/no-op: src=20 -> err=1, done pulses, reg_load stays 0.
//    src=0 -> done, no err. err_clr with a simultaneous new illegal src -> err stays 1.
//  - Reset mid-DRIVE: rst_n low -> mux_sel, reg_load, busy go 0 immediately; no load occurs.
//    After release, the next request is granted to requester 0 first.
//  - SETTLE=3 build: same as the single case, with load on cycle 4; mux_sel stable for 4 cycles.

Source files
------------

// File: rtl/bus_transfer_sequencer_pkg.sv
// Shared constants, state encoding and helpers for the register-bus transfer sequencer.
package bus_pkg;

  localparam int NREGS    = 16;
  localparam int SEL_W    = 5;
  localparam int SEL_NONE = 0;
  localparam int SEL_EXT  = NREGS + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    LOAD  = 2'd2
  } state_t;

  // Mux select code that puts register r<idx> on the bus.
  function automatic logic [SEL_W-1:0] reg_sel(input logic [3:0] idx);
    return SEL_W'(idx) + SEL_W'(1);
  endfunction

endpackage

// File: rtl/bus_transfer_sequencer_rr_arbiter.sv
// Combinational round-robin arbiter: the search starts at ptr and wraps; the grant is one-hot.
module rr_arbiter #(
  parameter int NREQ = 2,
  parameter int PW   = 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] gnt
);

  logic [2*NREQ-1:0] dbl;
  logic [2*NREQ-1:0] back;
  logic [NREQ-1:0]   rot;
  logic [NREQ-1:0]   pick;

  // Rotate so the pointer sits at bit 0, keep the lowest set bit, rotate back.
  assign dbl  = {req, req} >> ptr;
  assign rot  = dbl[NREQ-1:0];
  assign pick = rot & (~rot + NREQ'(1));
  assign back = {pick, pick} << ptr;
  assign gnt  = back[2*NREQ-1:NREQ];

endmodule

// File: rtl/bus_transfer_sequencer.sv
// Owns the shared register bus: arbitrates transfer requests round-robin, drives the mux
// select for SETTLE cycles, then strobes exactly one destination load and a done pulse.
// Handshake: a request is accepted on a rising edge where req_valid[i] & req_ready[i];
// req_ready is one-hot and only offered in IDLE, so at most one transfer is in flight.
module bus_transfer_sequencer
  import bus_pkg::*;
#(
  parameter int NREQ   = 2,
  parameter int NREGS  = 16,
  parameter int SEL_W  = 5,
  parameter int SETTLE = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*SEL_W-1:0] req_src,
  input  logic [NREQ*4-1:0]     req_dst,
  output logic [NREQ-1:0]       req_ready,
  output logic [NREQ-1:0]       done,
  output logic [SEL_W-1:0]      mux_sel,
  output logic                  ext_drive,
  output logic [NREGS-1:0]      reg_load,
  output logic                  busy,
  output logic                  err,
  input  logic                  err_clr,
  output logic [1:0]            dbg_state
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [SEL_W-1:0] SEL_EXT_C = SEL_W'(NREGS + 1);

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [3:0]      dst_q;
  logic [NREQ-1:0] gid_q;
  logic [PW-1:0]   ptr;

  logic [NREQ-1:0] gnt;
  logic [PW-1:0]   gidx;
  logic [PW-1:0]   ptr_nxt;
  logic [SEL_W-1:0] sel_src;
  logic [3:0]      sel_dst;
  logic            accept;
  logic            drive_ok;
  logic            illegal;

  rr_arbiter #(.NREQ(NREQ), .PW(PW)) u_arb (
    .req (req_valid),
    .ptr (ptr),
    .gnt (gnt)
  );

  assign req_ready = (rst_n && state == IDLE) ? gnt : '0;
  assign accept    = |req_ready;
  assign busy      = (state != IDLE);
  assign dbg_state = state;

  // Select the granted requester's source/destination and its index.
  always_comb begin
    gidx    = '0;
    sel_src = '0;
    sel_dst = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        gidx    = PW'(i);
        sel_src = req_src[i*SEL_W +: SEL_W];
        sel_dst = req_dst[i*4 +: 4];
      end
    end
  end

  assign ptr_nxt  = (gidx == PW'(NREQ - 1)) ? '0 : gidx + PW'(1);
  assign drive_ok = (sel_src != '0) && (sel_src <= SEL_EXT_C);
  assign illegal  = (sel_src > SEL_EXT_C);

  // Transfer FSM; all bus-facing outputs are registered so they change only on the clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      dst_q     <= '0;
      gid_q     <= '0;
      ptr       <= '0;
      mux_sel   <= '0;
      ext_drive <= 1'b0;
      reg_load  <= '0;
      done      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            dst_q <= sel_dst;
            gid_q <= gnt;
            ptr   <= ptr_nxt;
            if (drive_ok) begin
              state     <= DRIVE;
              cnt       <= '0;
              mux_sel   <= sel_src;
              ext_drive <= (sel_src == SEL_EXT_C);
            end else begin
              // No-op and illegal sources skip the bus entirely but still complete.
              state <= LOAD;
              done  <= gnt;
            end
          end
        end
        DRIVE: begin
          if (cnt == CW'(SETTLE - 1)) begin
            state    <= LOAD;
            reg_load <= NREGS'(1) << dst_q;
            done     <= gid_q;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        LOAD: begin
          state     <= IDLE;
          mux_sel   <= '0;
          ext_drive <= 1'b0;
          reg_load  <= '0;
          done      <= '0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Sticky illegal-source flag; a new error beats a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else if (accept && illegal) begin
      err <= 1'b1;
    end else if (err_clr) begin
      err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bus_transfer_sequencer.sv
// Directed bench for bus_transfer_sequencer with a done-pulse scoreboard.
module tb_bus_transfer_sequencer;
  import bus_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT (SETTLE=1) ----------------
  logic [1:0]  req_valid = '0;
  logic [9:0]  req_src = '0;
  logic [7:0]  req_dst = '0;
  logic        err_clr = 1'b0;
  logic [1:0]  req_ready, done, dbg_state;
  logic [4:0]  mux_sel;
  logic        ext_drive, busy, err;
  logic [15:0] reg_load;

  bus_transfer_sequencer u_dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_src(req_src), .req_dst(req_dst),
    .req_ready(req_ready), .done(done), .mux_sel(mux_sel), .ext_drive(ext_drive),
    .reg_load(reg_load), .busy(busy), .err(err), .err_clr(err_clr), .dbg_state(dbg_state)
  );

  // ---------------- DUT (SETTLE=3) ----------------
  logic [1:0]  v3 = '0;
  logic [9:0]  s3 = '0;
  logic [7:0]  d3 = '0;
  logic [1:0]  ready3, done3, dbg3;
  logic [4:0]  mux3;
  logic        ext3, busy3, err3;
  logic [15:0] load3;

  bus_transfer_sequencer #(.SETTLE(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .req_valid(v3), .req_src(s3), .req_dst(d3),
    .req_ready(ready3), .done(done3), .mux_sel(mux3), .ext_drive(ext3),
    .reg_load(load3), .busy(busy3), .err(err3), .err_clr(1'b0), .dbg_state(dbg3)
  );

  // ---------------- checking ----------------
  int checks = 0;
  int errors = 0;
  int ptr_m  = 0;
  logic [23:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected completion: {done, reg_load, mux_sel, ext_drive} in the LOAD cycle.
  function automatic logic [23:0] exp_entry(input int g, input logic [4:0] src, input logic [3:0] dst);
    logic        drv;
    logic [1:0]  d;
    logic [15:0] ld;
    logic [4:0]  m;
    drv = (src != 5'd0) && (src <= 5'd17);
    d   = (g == 0) ? 2'b01 : 2'b10;
    ld  = drv ? (16'h0001 << dst) : 16'h0000;
    m   = drv ? src : 5'd0;
    return {d, ld, m, (src == 5'd17)};
  endfunction

  // Scoreboard: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    logic [23:0] e;
    if (rst_n && done != 2'b00) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_done", {30'd0, done}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("sb_xfer", {8'd0, done, reg_load, mux_sel, ext_drive}, {8'd0, e});
      end
    end
  end

  // ---------------- driver ----------------
  // Called just after a falling edge; returns #1 after the accepting rising edge.
  task automatic send(input int id, input logic [4:0] src, input logic [3:0] dst);
    int n;
    n = 0;
    if (id == 0) begin
      req_src[4:0] = src; req_dst[3:0] = dst; req_valid[0] = 1'b1;
    end else begin
      req_src[9:5] = src; req_dst[7:4] = dst; req_valid[1] = 1'b1;
    end
    #1;
    while (req_ready[id] !== 1'b1 && n < 20) begin
      @(negedge clk); #1; n++;
    end
    if (n >= 20) begin
      check("send_timeout", n, 0);
      req_valid = '0;
    end else begin
      check("send_gnt", {30'd0, req_ready}, (id == 0) ? 32'd1 : 32'd2);
      exp_q.push_back(exp_entry(id, src, dst));
      ptr_m = (id == 0) ? 1 : 0;
      @(posedge clk); #1;
      req_valid = '0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int grants, cyc, last_cyc;
    logic [23:0] dropped;

    // Reset state, with requests already pending.
    req_valid = 2'b11;
    repeat (2) @(negedge clk);
    check("rst_mux", mux_sel, 0);
    check("rst_load", reg_load, 0);
    check("rst_done", done, 0);
    check("rst_ready", req_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    check("rst_state", dbg_state, IDLE);

    // Contention straight out of reset: 0,1,0,1, SETTLE+2 apart, idle bus at each grant.
    req_src = {reg_sel(4'd3), reg_sel(4'd1)};
    req_dst = {4'd9, 4'd8};
    rst_n = 1'b1;
    grants = 0; cyc = 0; last_cyc = -1;
    while (grants < 4 && cyc < 40) begin
      #1;
      if (req_ready != 2'b00) begin
        check("cont_gnt", req_ready, (ptr_m == 0) ? 2'b01 : 2'b10);
        check("cont_idle_mux", mux_sel, 0);
        if (last_cyc >= 0) check("cont_spacing", cyc - last_cyc, 3);
        exp_q.push_back(exp_entry(ptr_m, (ptr_m == 0) ? 5'd2 : 5'd4, (ptr_m == 0) ? 4'd8 : 4'd9));
        ptr_m = (ptr_m == 0) ? 1 : 0;
        last_cyc = cyc;
        grants++;
        if (grants == 4) begin
          @(posedge clk); #1;
          req_valid = 2'b00;
        end
      end
      @(negedge clk);
      cyc++;
    end
    if (grants < 4) check("cont_timeout", grants, 4);

    // Single transfer r2 -> r5 with cycle-exact checks.
    send(0, reg_sel(4'd2), 4'd5);
    @(negedge clk);
    check("single_c1_mux", mux_sel, 3);
    check("single_c1_load", reg_load, 0);
    check("single_c1_state", dbg_state, DRIVE);
    @(negedge clk);
    check("single_c2_mux", mux_sel, 3);
    check("single_c2_load", reg_load, 16'h0020);
    check("single_c2_done", done, 2'b01);
    check("single_c2_state", dbg_state, LOAD);
    @(negedge clk);
    check("single_c3_busy", busy, 0);
    check("single_c3_mux", mux_sel, 0);

    // External data into r15.
    send(1, 5'd17, 4'd15);
    @(negedge clk);
    check("ext_c1_drive", ext_drive, 1);
    check("ext_c1_mux", mux_sel, 17);
    @(negedge clk);
    check("ext_c2_drive", ext_drive, 1);
    check("ext_c2_load", reg_load, 16'h8000);
    @(negedge clk);
    check("ext_c3_drive", ext_drive, 0);

    // Illegal source: error, done, no load.
    send(0, 5'd20, 4'd3);
    @(negedge clk);
    check("ill_err", err, 1);
    check("ill_done", done, 2'b01);
    check("ill_load", reg_load, 0);
    check("ill_mux", mux_sel, 0);
    @(negedge clk);
    check("ill_idle", busy, 0);

    // Clear alone.
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    @(negedge clk);
    check("clr_err", err, 0);

    // No-op source.
    send(1, 5'd0, 4'd4);
    @(negedge clk);
    check("noop_done", done, 2'b10);
    check("noop_load", reg_load, 0);
    check("noop_err", err, 0);

    // Clear coinciding with a new illegal request: set wins.
    err_clr = 1'b1;
    send(0, 5'd21, 4'd2);
    err_clr = 1'b0;
    @(negedge clk);
    check("setwins_err", err, 1);
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    @(negedge clk);
    check("clr2_err", err, 0);

    // Self-copy r5 -> r5.
    send(1, reg_sel(4'd5), 4'd5);
    @(negedge clk);
    @(negedge clk);
    check("self_load", reg_load, 16'h0020);
    check("self_mux", mux_sel, 6);

    // Reset in the middle of DRIVE: outputs clear at once and the load never happens.
    @(negedge clk);
    send(0, reg_sel(4'd1), 4'd7);
    check("rstmid_busy_before", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check("rstmid_mux", mux_sel, 0);
    check("rstmid_busy", busy, 0);
    check("rstmid_load", reg_load, 0);
    dropped = exp_q.pop_back();
    req_src = {reg_sel(4'd4), reg_sel(4'd6)};
    req_dst = {4'd11, 4'd12};
    req_valid = 2'b11;
    @(negedge clk);
    check("rstmid_hold_load", reg_load, 0);
    check("rstmid_hold_ready", req_ready, 0);
    rst_n = 1'b1;
    ptr_m = 0;
    #1;
    check("rstmid_regrant", req_ready, 2'b01);
    exp_q.push_back(exp_entry(0, reg_sel(4'd6), 4'd12));
    ptr_m = 1;
    @(posedge clk); #1;
    req_valid = 2'b00;
    repeat (4) @(negedge clk);

    // SETTLE=3 build: drive for three cycles, load on cycle 4.
    v3 = 2'b01;
    s3 = {5'd0, reg_sel(4'd2)};
    d3 = {4'd0, 4'd5};
    #1;
    check("s3_ready", ready3, 2'b01);
    @(posedge clk); #1;
    v3 = 2'b00;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      check("s3_drive_mux", mux3, 3);
      check("s3_drive_load", load3, 0);
    end
    @(negedge clk);
    check("s3_c4_load", load3, 16'h0020);
    check("s3_c4_done", done3, 2'b01);
    check("s3_c4_mux", mux3, 3);
    @(negedge clk);
    check("s3_c5_busy", busy3, 0);
    check("s3_c5_mux", mux3, 0);

    repeat (4) @(negedge clk);
    check("sb_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
